// File: rtl/systolic_tile_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : systolic_sched_pkg                                               |
// | Shared sizes and types for the tiled-GEMM scheduler: array geometry,       |
// | accumulator width, tile-index type, C-tile type and FSM state encoding.    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package systolic_sched_pkg;

   localparam int ROWS = 4;    // array rows, C tile height
   localparam int COLS = 4;    // array columns, C tile width
   localparam int ACCW = 32;   // accumulator / result width, signed
   localparam int DIMW = 8;    // width of tile counts and tile indices

   typedef logic [DIMW-1:0]        tile_idx_t;
   typedef logic signed [ACCW-1:0] acc_t;
   // Packed so that a whole tile moves as one ROWS*COLS*ACCW-bit bus.
   typedef acc_t [ROWS-1:0][COLS-1:0] psum_tile_t;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_START  = 3'd2,
      S_WAIT   = 3'd3,
      S_OUTPUT = 3'd4
   } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/systolic_tile_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : systolic_tile_scheduler_if                                     |
// | Bundles the command, operand-fetch, array and result ports of the          |
// | scheduler.  master = scheduler side, slave = environment side.             |
// |   command : cmd_valid/cmd_ready, cmd_{m,n,k}_tiles, abort, busy,           |
// |             cmd_done, cmd_aborted                                          |
// |   fetch   : fetch_req, fetch_{m,n,k}, fetch_ack                            |
// |   array   : arr_start, arr_done, arr_c                                     |
// |   result  : res_valid, res_ready, res_m, res_n, res_data                   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface systolic_tile_scheduler_if;

   logic                          cmd_valid;
   logic                          cmd_ready;
   systolic_sched_pkg::tile_idx_t cmd_m_tiles;
   systolic_sched_pkg::tile_idx_t cmd_n_tiles;
   systolic_sched_pkg::tile_idx_t cmd_k_tiles;
   logic                          abort;
   logic                          busy;
   logic                          cmd_done;
   logic                          cmd_aborted;

   logic                          fetch_req;
   systolic_sched_pkg::tile_idx_t fetch_m;
   systolic_sched_pkg::tile_idx_t fetch_n;
   systolic_sched_pkg::tile_idx_t fetch_k;
   logic                          fetch_ack;

   logic                           arr_start;
   logic                           arr_done;
   systolic_sched_pkg::psum_tile_t arr_c;

   logic                           res_valid;
   logic                           res_ready;
   systolic_sched_pkg::tile_idx_t  res_m;
   systolic_sched_pkg::tile_idx_t  res_n;
   systolic_sched_pkg::psum_tile_t res_data;

   modport master (
      input  cmd_valid, cmd_m_tiles, cmd_n_tiles, cmd_k_tiles, abort,
             fetch_ack, arr_done, arr_c, res_ready,
      output cmd_ready, busy, cmd_done, cmd_aborted,
             fetch_req, fetch_m, fetch_n, fetch_k,
             arr_start, res_valid, res_m, res_n, res_data
   );

   modport slave (
      output cmd_valid, cmd_m_tiles, cmd_n_tiles, cmd_k_tiles, abort,
             fetch_ack, arr_done, arr_c, res_ready,
      input  cmd_ready, busy, cmd_done, cmd_aborted,
             fetch_req, fetch_m, fetch_n, fetch_k,
             arr_start, res_valid, res_m, res_n, res_data
   );

endinterface
`default_nettype wire

// File: rtl/systolic_tile_scheduler_psum_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : psum_bank                                                        |
// | ROWS x COLS bank of ACCW-bit partial-sum registers.                        |
// |   clk, rst_n : clock, synchronous active-low clear                         |
// |   load       : overwrite every element with arr_c                          |
// |   add        : accumulate arr_c elementwise (two's-complement wrap)        |
// |   arr_c      : incoming array tile                                         |
// |   psum       : stored tile                                                 |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module psum_bank
   import systolic_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       add,
   input  psum_tile_t arr_c,
   output psum_tile_t psum
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         psum <= '0;
      end else begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               if (load) begin
                  psum[r][c] <= arr_c[r][c];
               end else if (add) begin
                  // Same-width add: overflow simply wraps.
                  psum[r][c] <= psum[r][c] + arr_c[r][c];
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/systolic_tile_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : systolic_tile_scheduler                                          |
// | Runs an M x N x K (in tiles) GEMM on one systolic array: fetches operand   |
// | tiles, starts the array, accumulates its C tiles over K and emits each     |
// | finished C tile on a valid/ready port, loop order m, n, k (k innermost).   |
// |   clk   : clock, rising edge                                               |
// |   rst_n : synchronous active-low reset                                     |
// |   bus   : command / fetch / array / result signals (master side)           |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module systolic_tile_scheduler
   import systolic_sched_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   systolic_tile_scheduler_if.master  bus
);

   sched_state_e state, state_nx;

   tile_idx_t m_tiles, n_tiles, k_tiles;
   tile_idx_t m, n, k;
   logic      abort_pend;
   logic      cmd_done_r, cmd_aborted_r, fetch_req_r, arr_start_r, res_valid_r;

   logic do_accept, do_capture, do_abort, do_hs, do_finish;
   logic cmd_zero, k_last, mn_last;

   assign cmd_zero = (bus.cmd_m_tiles == '0) || (bus.cmd_n_tiles == '0) ||
                     (bus.cmd_k_tiles == '0);
   assign k_last   = (k == k_tiles - tile_idx_t'(1));
   assign mn_last  = (m == m_tiles - tile_idx_t'(1)) && (n == n_tiles - tile_idx_t'(1));

   always_comb begin
      state_nx   = state;
      do_accept  = 1'b0;
      do_capture = 1'b0;
      do_abort   = 1'b0;
      do_hs      = 1'b0;
      do_finish  = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               do_accept = 1'b1;
               if (cmd_zero) begin
                  do_finish = 1'b1;
               end else begin
                  state_nx = S_FETCH;
               end
            end
         end
         S_FETCH: begin
            // Abort outranks a same-cycle fetch_ack.
            if (bus.abort) begin
               state_nx = S_IDLE;
               do_abort = 1'b1;
            end else if (bus.fetch_ack) begin
               state_nx = S_START;
            end
         end
         S_START: state_nx = S_WAIT;
         S_WAIT: begin
            // The array is never abandoned mid-run; an abort seen in START/WAIT
            // is honoured only once the array reports done.
            if (bus.arr_done) begin
               if (abort_pend || bus.abort) begin
                  state_nx = S_IDLE;
                  do_abort = 1'b1;
               end else begin
                  do_capture = 1'b1;
                  state_nx   = k_last ? S_OUTPUT : S_FETCH;
               end
            end
         end
         S_OUTPUT: begin
            if (bus.abort) begin
               state_nx = S_IDLE;
               do_abort = 1'b1;
            end else if (bus.res_ready) begin
               do_hs = 1'b1;
               if (mn_last) begin
                  state_nx  = S_IDLE;
                  do_finish = 1'b1;
               end else begin
                  state_nx = S_FETCH;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         m_tiles       <= '0;
         n_tiles       <= '0;
         k_tiles       <= '0;
         m             <= '0;
         n             <= '0;
         k             <= '0;
         abort_pend    <= 1'b0;
         cmd_done_r    <= 1'b0;
         cmd_aborted_r <= 1'b0;
         fetch_req_r   <= 1'b0;
         arr_start_r   <= 1'b0;
         res_valid_r   <= 1'b0;
      end else begin
         state         <= state_nx;
         cmd_done_r    <= do_finish;
         cmd_aborted_r <= do_abort;
         // Strobes are decoded from the next state so they are registered yet
         // line up exactly with the state they belong to.
         fetch_req_r   <= (state_nx == S_FETCH);
         arr_start_r   <= (state_nx == S_START);
         res_valid_r   <= (state_nx == S_OUTPUT);

         if (state == S_START || (state == S_WAIT && !bus.arr_done)) begin
            abort_pend <= abort_pend | bus.abort;
         end else begin
            abort_pend <= 1'b0;
         end

         if (do_accept) begin
            m_tiles <= bus.cmd_m_tiles;
            n_tiles <= bus.cmd_n_tiles;
            k_tiles <= bus.cmd_k_tiles;
            m       <= '0;
            n       <= '0;
            k       <= '0;
         end

         if (do_capture && !k_last) begin
            k <= k + tile_idx_t'(1);
         end

         if (do_hs) begin
            k <= '0;
            if (n == n_tiles - tile_idx_t'(1)) begin
               n <= '0;
               m <= mn_last ? '0 : m + tile_idx_t'(1);
            end else begin
               n <= n + tile_idx_t'(1);
            end
         end
      end
   end

   psum_bank u_psum_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (do_capture && (k == '0)),
      .add   (do_capture && (k != '0)),
      .arr_c (bus.arr_c),
      .psum  (bus.res_data)
   );

   // m/n/k are registers held stable for the whole FETCH and OUTPUT phases.
   assign bus.cmd_ready   = (state == S_IDLE);
   assign bus.busy        = (state != S_IDLE);
   assign bus.cmd_done    = cmd_done_r;
   assign bus.cmd_aborted = cmd_aborted_r;
   assign bus.fetch_req   = fetch_req_r;
   assign bus.fetch_m     = m;
   assign bus.fetch_n     = n;
   assign bus.fetch_k     = k;
   assign bus.arr_start   = arr_start_r;
   assign bus.res_valid   = res_valid_r;
   assign bus.res_m       = m;
   assign bus.res_n       = n;

endmodule
`default_nettype wire

// File: doc/systolic_tile_scheduler.md
# systolic_tile_scheduler

Sequencer that runs a tiled GEMM (M×N×K, given in tiles) on one 4×4 systolic MAC array. It accepts a command, requests operand tiles from the fetch unit, pulses the array's start, and waits for its done. It accumulates the array's per-tile results across the K dimension in a local partial-sum bank and emits each finished C tile on a valid/ready result port. It sits between the command interface and the array/operand-fetch datapath.

## Interface
- ROWS, 4, array rows (C tile height)
- COLS, 4, array columns (C tile width)
- ACCW, 32, accumulator/result width, signed
- DIMW, 8, width of tile counts and tile indices
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_m_tiles, cmd_n_tiles, cmd_k_tiles  in  DIMW each  tile counts, unsigned
- abort  in  1  level; request to abandon the current command
- busy  out  1  state != IDLE
- cmd_done  out  1  one-cycle pulse, command completed normally
- cmd_aborted  out  1  one-cycle pulse, command abandoned
- fetch_req  out  1  operand tile request; held until fetch_ack
- fetch_m, fetch_n, fetch_k  out  DIMW each  requested tile indices, stable while fetch_req=1
- fetch_ack  in  1  operands loaded into the array inputs
- arr_start  out  1  one-cycle start pulse to the array
- arr_done  in  1  array done pulse, C valid in the same cycle
- arr_c  in  ROWS×COLS×ACCW  array result tile, signed
- res_valid  out  1  C tile available
- res_ready  in  1  consumer accepts
- res_m, res_n  out  DIMW each  tile indices of res_data
- res_data  out  ROWS×COLS×ACCW  accumulated C tile, signed

## Operation
- States: IDLE, FETCH, START, WAIT, OUTPUT.
- IDLE: on cmd_valid, latch the three counts and set m=n=k=0.
  - If any count is 0, pulse cmd_done next cycle and stay in IDLE.
  - Otherwise go to FETCH.
- FETCH: assert fetch_req with (m,n,k). A fetch_ack in the same cycle as fetch_req is legal; it moves to START.
- START: arr_start=1 for exactly one cycle, then WAIT.
- WAIT: arr_done captures the tile.
  - k==0: psum <= arr_c. Otherwise psum <= psum + arr_c, elementwise, two's-complement wrap at ACCW (no saturation).
  - If k==k_tiles-1, go to OUTPUT; else increment k and go to FETCH.
- OUTPUT: res_valid=1, res_data=psum, res_m=m, res_n=n, all held stable until res_ready.
  - On the handshake: k=0 and n increments. At n==n_tiles-1, n=0 and m increments.
  - After the last (m,n), pulse cmd_done and go to IDLE. Otherwise go to FETCH.
- Loop order is m outer, n middle, k inner. Results are emitted row-major by tile.
- Abort:
  - Sampled in FETCH and OUTPUT: the next state is IDLE, cmd_aborted pulses, fetch_req/res_valid drop. An in-flight fetch_ack in that same cycle is ignored.
  - In START or WAIT, abort is latched as pending and acted on at the cycle arr_done is received; psum is not output. This means arr_start is never issued while the array is running.
- arr_done outside WAIT is ignored. fetch_ack outside FETCH is ignored.

## Timing
- Reset (rst_n=0 at a clock edge): state=IDLE.
  - busy, cmd_done, cmd_aborted, fetch_req, arr_start, res_valid = 0.
  - fetch_*/res_m/res_n = 0; psum and res_data = 0; pending abort cleared.
  - cmd_ready=1 from the first cycle after reset.
- Reset in any state takes effect at the next edge. A command in flight is lost without a cmd_done or cmd_aborted pulse.
- All outputs are registered except cmd_ready and busy, which are state decodes.
- Per k-step overhead beyond array latency: FETCH (≥1 cycle) + START (1) + 1 cycle WAIT→FETCH. Minimum 3 cycles plus the array run.
- OUTPUT lasts ≥1 cycle. res_ready held high gives a 1-cycle handshake.
- cmd_done asserts in the cycle after the final result handshake; cmd_ready is high in that same cycle.
- A command is accepted in the same cycle cmd_valid && cmd_ready.

## Structure
- Package systolic_sched_pkg holds:
  - state enum sched_state_e
  - typedef tile_idx_t (logic [DIMW-1:0])
  - typedef psum_tile_t (signed [ACCW-1:0] [ROWS][COLS])
  - ROWS/COLS defaults
- One sub-module, psum_bank: ROWS×COLS ACCW-bit registers.
  - Inputs: load (overwrite with arr_c), add (accumulate arr_c), sync clear on reset.
  - Output: the stored tile, driving res_data.
- The FSM and index counters live in the top module.

## Test plan
- Command 1×1×1, array model returns C[i][j]=i*4+j: exactly one fetch (0,0,0) and one arr_start. res_data equals C and res_m=res_n=0; cmd_done one cycle after the handshake.
- Command 1×1×3, array returns all 5, then all -2, then all 7: one result with every element 10. Three fetches with k=0,1,2.
- Command 2×2×1: results emitted in order (0,0),(0,1),(1,0),(1,1). Hold res_ready low 5 cycles on the second result: res_valid and res_data stay stable, and no further fetch_req is issued.
- Command with k_tiles=0: cmd_done pulses next cycle, with no fetch_req and no arr_start. Also inject a wrap case: 0x7FFFFFFF + 1 accumulates to 0x80000000.
- Abort asserted in WAIT: no action until arr_done, then cmd_aborted pulses, with no res_valid and no cmd_done. Abort in FETCH yields cmd_aborted the next cycle.
- rst_n low for 1 cycle mid-WAIT: all outputs return to reset values and cmd_ready=1 next cycle. A late arr_done is ignored, and a new 1×1×1 command completes correctly.
